// File: rtl/apb_ctrl_pkg.sv
// Shared types and constants for the APB manager/arbiter slice.
package apb_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // APB prot bit masks
  localparam logic [3:0] ProtPrivileged  = 4'b0001;
  localparam logic [3:0] ProtNonSecure   = 4'b0010;
  localparam logic [3:0] ProtInstruction = 4'b0100;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter: first requester after the last grant wins; pointer moves on accept.
module apb_rr_arbiter #(
  parameter  int unsigned ReqNum = 2,
  localparam int unsigned IdxW   = (ReqNum > 1) ? $clog2(ReqNum) : 1
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic [ReqNum-1:0] req,
  input  logic              accept,
  output logic [ReqNum-1:0] grant_c,
  output logic [IdxW-1:0]   grant_idx_c,
  output logic              any_c
);

  logic [IdxW-1:0] last_grant;

  // Search starting one past the last grant, wrapping modulo ReqNum
  always_comb begin
    logic            found;
    logic [IdxW-1:0] cand;
    found       = 1'b0;
    cand        = '0;
    grant_idx_c = '0;
    grant_c     = '0;
    for (int k = 1; k <= int'(ReqNum); k++) begin
      cand = IdxW'((int'(last_grant) + k) % int'(ReqNum));
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant_idx_c = cand;
      end
    end
    if (found) grant_c[grant_idx_c] = 1'b1;
    any_c = found;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      last_grant <= IdxW'(ReqNum - 1);
    end else if (accept) begin
      last_grant <= grant_idx_c;
    end
  end

endmodule

// File: rtl/apb_manager_arbiter.sv
// APB manager shared by ReqNum requesters: round-robin grant, address decode,
// SETUP/ACCESS sequencing with watchdog, and per-requester response pulse.
module apb_manager_arbiter
  import apb_ctrl_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned PrphNum   = 4,
  parameter int unsigned ReqNum    = 2,
  parameter int unsigned PrphShift = 12,
  parameter int unsigned Timeout   = 256
) (
  input  logic                          clk,
  input  logic                          nReset,
  input  logic [ReqNum-1:0]             reqValid,
  output logic [ReqNum-1:0]             reqReady,
  input  logic [ReqNum*AddrWidth-1:0]   reqAddr,
  input  logic [ReqNum-1:0]             reqWrite,
  input  logic [ReqNum*DataWidth-1:0]   reqWData,
  input  logic [ReqNum*DataWidth/8-1:0] reqStrb,
  input  logic [ReqNum*4-1:0]           reqProt,
  output logic [ReqNum-1:0]             rspValid,
  output logic [DataWidth-1:0]          rspRData,
  output logic                          rspError,
  output logic [AddrWidth-1:0]          addr,
  output logic [3:0]                    prot,
  output logic [PrphNum-1:0]            selectors,
  output logic                          enable,
  output logic                          write,
  output logic [DataWidth-1:0]          wData,
  output logic [DataWidth/8-1:0]        strb,
  input  logic                          ready,
  input  logic [DataWidth-1:0]          rData,
  input  logic                          subError
);

  localparam int unsigned StrbW = DataWidth / 8;
  localparam int unsigned IdxW  = (ReqNum > 1) ? $clog2(ReqNum) : 1;
  localparam int unsigned CntW  = (Timeout > 0) ? $clog2(Timeout + 1) : 1;
  localparam int unsigned WdMax = (Timeout > 0) ? Timeout - 1 : 0;

  apb_state_e state, state_d;

  logic [ReqNum-1:0] grant_c;
  logic [IdxW-1:0]   grant_idx_c;
  logic              any_c;
  logic              accept_c, go_bus_c, dec_err_c, done_c, abort_c;
  logic [ReqNum-1:0] lat_gnt;
  logic [CntW-1:0]   wd_cnt;

  logic [AddrWidth-1:0] req_addr_a  [ReqNum];
  logic [DataWidth-1:0] req_wdata_a [ReqNum];
  logic [StrbW-1:0]     req_strb_a  [ReqNum];
  logic [3:0]           req_prot_a  [ReqNum];

  logic [AddrWidth-1:0] sel_addr_c;
  logic [AddrWidth-1:0] sel_pidx_c;
  logic [PrphNum-1:0]   sel_onehot_c;
  logic                 in_range_c;

  apb_rr_arbiter #(.ReqNum(ReqNum)) u_arb (
    .clk        (clk),
    .nReset     (nReset),
    .req        (reqValid),
    .accept     (accept_c),
    .grant_c    (grant_c),
    .grant_idx_c(grant_idx_c),
    .any_c      (any_c)
  );

  // Unpack requester lanes
  always_comb begin
    for (int i = 0; i < int'(ReqNum); i++) begin
      req_addr_a[i]  = reqAddr[i*AddrWidth +: AddrWidth];
      req_wdata_a[i] = reqWData[i*DataWidth +: DataWidth];
      req_strb_a[i]  = reqStrb[i*StrbW +: StrbW];
      req_prot_a[i]  = reqProt[i*4 +: 4];
    end
  end

  // Peripheral decode of the granted requester's address
  always_comb begin
    sel_addr_c   = req_addr_a[grant_idx_c];
    sel_pidx_c   = sel_addr_c >> PrphShift;
    in_range_c   = (sel_pidx_c < AddrWidth'(PrphNum));
    sel_onehot_c = '0;
    for (int p = 0; p < int'(PrphNum); p++) begin
      sel_onehot_c[p] = (sel_pidx_c == AddrWidth'(p));
    end
  end

  assign reqReady = (state == IDLE) ? grant_c : '0;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= state_d;
  end

  // Next-state and transfer event strobes
  always_comb begin
    state_d   = state;
    accept_c  = 1'b0;
    go_bus_c  = 1'b0;
    dec_err_c = 1'b0;
    done_c    = 1'b0;
    abort_c   = 1'b0;
    case (state)
      IDLE: begin
        if (any_c) begin
          accept_c = 1'b1;
          if (in_range_c) begin
            go_bus_c = 1'b1;
            state_d  = SETUP;
          end else begin
            dec_err_c = 1'b1;
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (ready) begin
          done_c  = 1'b1;
          state_d = IDLE;
        end else if ((Timeout != 0) && (wd_cnt == CntW'(WdMax))) begin
          abort_c = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Watchdog counts ACCESS cycles spent waiting for ready
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      wd_cnt <= '0;
    end else if (state == SETUP) begin
      wd_cnt <= '0;
    end else if ((state == ACCESS) && !ready) begin
      wd_cnt <= wd_cnt + CntW'(1);
    end
  end

  // Bus and response registers
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      lat_gnt   <= '0;
      addr      <= '0;
      prot      <= '0;
      write     <= 1'b0;
      wData     <= '0;
      strb      <= '0;
      selectors <= '0;
      enable    <= 1'b0;
      rspValid  <= '0;
      rspRData  <= '0;
      rspError  <= 1'b0;
    end else begin
      rspValid <= '0;
      if (accept_c) lat_gnt <= grant_c;
      if (go_bus_c) begin
        addr      <= sel_addr_c;
        prot      <= req_prot_a[grant_idx_c];
        write     <= reqWrite[grant_idx_c];
        wData     <= req_wdata_a[grant_idx_c];
        strb      <= reqWrite[grant_idx_c] ? req_strb_a[grant_idx_c] : '0;
        selectors <= sel_onehot_c;
        enable    <= 1'b0;
      end
      if (dec_err_c) begin
        rspValid <= grant_c;
        rspError <= 1'b1;
        rspRData <= '0;
      end
      if (state == SETUP) enable <= 1'b1;
      if (done_c) begin
        selectors <= '0;
        enable    <= 1'b0;
        rspValid  <= lat_gnt;
        rspError  <= subError;
        rspRData  <= write ? '0 : rData;
      end
      if (abort_c) begin
        selectors <= '0;
        enable    <= 1'b0;
        rspValid  <= lat_gnt;
        rspError  <= 1'b1;
        rspRData  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_manager_arbiter.sv
// Directed self-checking bench for apb_manager_arbiter (2 requesters, 4 peripherals, Timeout=8).
module tb_apb_manager_arbiter;
  import apb_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        nReset;
  logic [1:0]  reqValid;
  logic [1:0]  reqReady;
  logic [63:0] reqAddr;
  logic [1:0]  reqWrite;
  logic [63:0] reqWData;
  logic [7:0]  reqStrb;
  logic [7:0]  reqProt;
  logic [1:0]  rspValid;
  logic [31:0] rspRData;
  logic        rspError;
  logic [31:0] addr;
  logic [3:0]  prot;
  logic [3:0]  selectors;
  logic        enable;
  logic        write;
  logic [31:0] wData;
  logic [3:0]  strb;
  logic        ready;
  logic [31:0] rData;
  logic        subError;

  int errors = 0;
  int checks = 0;

  apb_manager_arbiter #(
    .AddrWidth(32), .DataWidth(32), .PrphNum(4), .ReqNum(2),
    .PrphShift(12), .Timeout(8)
  ) dut (
    .clk(clk), .nReset(nReset),
    .reqValid(reqValid), .reqReady(reqReady), .reqAddr(reqAddr),
    .reqWrite(reqWrite), .reqWData(reqWData), .reqStrb(reqStrb),
    .reqProt(reqProt), .rspValid(rspValid), .rspRData(rspRData),
    .rspError(rspError), .addr(addr), .prot(prot), .selectors(selectors),
    .enable(enable), .write(write), .wData(wData), .strb(strb),
    .ready(ready), .rData(rData), .subError(subError)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic [3:0] s, input logic [3:0] p);
    reqAddr[i*32 +: 32]  = a;
    reqWrite[i]          = w;
    reqWData[i*32 +: 32] = d;
    reqStrb[i*4 +: 4]    = s;
    reqProt[i*4 +: 4]    = p;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sel"},   32'(selectors), 32'h0);
    chk({tag, "_en"},    32'(enable),    32'h0);
    chk({tag, "_wr"},    32'(write),     32'h0);
    chk({tag, "_addr"},  addr,           32'h0);
    chk({tag, "_wdata"}, wData,          32'h0);
    chk({tag, "_strb"},  32'(strb),      32'h0);
    chk({tag, "_prot"},  32'(prot),      32'h0);
    chk({tag, "_rdy"},   32'(reqReady),  32'h0);
    chk({tag, "_rspv"},  32'(rspValid),  32'h0);
    chk({tag, "_rspd"},  rspRData,       32'h0);
    chk({tag, "_rspe"},  32'(rspError),  32'h0);
  endtask

  initial begin
    nReset = 1'b1; reqValid = '0; reqAddr = '0; reqWrite = '0; reqWData = '0;
    reqStrb = '0; reqProt = '0; ready = 1'b0; rData = '0; subError = 1'b0;
    #1 nReset = 1'b0;
    #1 chk_reset_outputs("rst");
    repeat (2) @(posedge clk);
    @(negedge clk) nReset = 1'b1;

    // Requester 0 zero-wait write to peripheral 1
    set_req(0, 32'h1004, 1'b1, 32'hDEADBEEF, 4'hF, ProtPrivileged);
    ready = 1'b1; reqValid = 2'b01;
    #1 chk("w_grant", 32'(reqReady), 32'h1);
    step(); reqValid = 2'b00;
    chk("w_setup_sel", 32'(selectors), 32'h2);
    chk("w_setup_en",  32'(enable),    32'h0);
    chk("w_addr",      addr,           32'h1004);
    chk("w_wdata",     wData,          32'hDEADBEEF);
    chk("w_strb",      32'(strb),      32'hF);
    chk("w_write",     32'(write),     32'h1);
    chk("w_prot",      32'(prot),      32'(ProtPrivileged));
    step();
    chk("w_access_en", 32'(enable),    32'h1);
    chk("w_access_sel",32'(selectors), 32'h2);
    step();
    chk("w_rspv",      32'(rspValid),  32'h1);
    chk("w_rspe",      32'(rspError),  32'h0);
    chk("w_idle_en",   32'(enable),    32'h0);
    chk("w_idle_sel",  32'(selectors), 32'h0);
    chk("w_addr_hold", addr,           32'h1004);

    // Requester 1 read with three wait states
    set_req(1, 32'h2000, 1'b0, 32'h0, 4'hF, ProtNonSecure);
    ready = 1'b0; reqValid = 2'b10;
    #1 chk("r_grant", 32'(reqReady), 32'h2);
    step(); reqValid = 2'b00;
    chk("r_setup_sel", 32'(selectors), 32'h4);
    chk("r_strb",      32'(strb),      32'h0);
    chk("r_write",     32'(write),     32'h0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("r_wait_en",   32'(enable),    32'h1);
      chk("r_wait_sel",  32'(selectors), 32'h4);
      chk("r_wait_addr", addr,           32'h2000);
      chk("r_wait_rspv", 32'(rspValid),  32'h0);
    end
    step();
    ready = 1'b1; rData = 32'h12345678;
    chk("r_last_en", 32'(enable), 32'h1);
    step();
    chk("r_rspv", 32'(rspValid), 32'h2);
    chk("r_rspd", rspRData,      32'h12345678);
    chk("r_rspe", 32'(rspError), 32'h0);
    rData = 32'h0;

    // Decode error: peripheral index 5 is out of range
    set_req(0, 32'h5000, 1'b0, 32'h0, 4'h0, 4'h0);
    reqValid = 2'b01;
    #1 chk("de_grant", 32'(reqReady), 32'h1);
    step(); reqValid = 2'b00;
    chk("de_rspv", 32'(rspValid),  32'h1);
    chk("de_rspe", 32'(rspError),  32'h1);
    chk("de_rspd", rspRData,       32'h0);
    chk("de_sel",  32'(selectors), 32'h0);
    chk("de_en",   32'(enable),    32'h0);
    chk("de_addr", addr,           32'h2000);
    step();
    chk("de_pulse", 32'(rspValid), 32'h0);

    // Both requesters held: alternate starting after last grant (0) -> 1,0,1,0
    set_req(0, 32'h0010, 1'b1, 32'h11111111, 4'h3, 4'h0);
    set_req(1, 32'h3020, 1'b1, 32'h22222222, 4'hC, 4'h0);
    reqValid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] g;
      g = (i % 2 == 0) ? 2'b10 : 2'b01;
      #1 chk("rr_grant", 32'(reqReady), 32'(g));
      step();
      if (i == 3) reqValid = 2'b00;
      chk("rr_sel", 32'(selectors), (g == 2'b10) ? 32'h8 : 32'h1);
      step();
      step();
      chk("rr_rspv", 32'(rspValid), 32'(g));
    end

    // Watchdog: requester 1, ready never asserted
    set_req(1, 32'h1000, 1'b1, 32'hCAFEF00D, 4'hF, 4'h0);
    ready = 1'b0; reqValid = 2'b10;
    #1 chk("to_grant", 32'(reqReady), 32'h2);
    step(); reqValid = 2'b00;
    for (int c = 0; c < 8; c++) begin
      step();
      chk("to_wait_en", 32'(enable), 32'h1);
    end
    step();
    chk("to_en",   32'(enable),    32'h0);
    chk("to_sel",  32'(selectors), 32'h0);
    chk("to_rspv", 32'(rspValid),  32'h2);
    chk("to_rspe", 32'(rspError),  32'h1);
    chk("to_rspd", rspRData,       32'h0);

    // Slave error on read: requester 0
    set_req(0, 32'h0000, 1'b0, 32'h0, 4'hF, 4'h0);
    ready = 1'b1; subError = 1'b1; rData = 32'hAAAA5555; reqValid = 2'b01;
    #1 chk("se_grant", 32'(reqReady), 32'h1);
    step(); reqValid = 2'b00;
    step();
    step();
    chk("se_rspv", 32'(rspValid), 32'h1);
    chk("se_rspe", 32'(rspError), 32'h1);
    chk("se_rspd", rspRData,      32'hAAAA5555);
    subError = 1'b0;

    // Reset asserted in ACCESS
    set_req(1, 32'h3000, 1'b1, 32'h55AA55AA, 4'hF, ProtInstruction);
    ready = 1'b0; reqValid = 2'b10;
    #1 chk("ra_grant", 32'(reqReady), 32'h2);
    step(); reqValid = 2'b00;
    step();
    chk("ra_access_en", 32'(enable), 32'h1);
    #2 nReset = 1'b0;
    #1 chk_reset_outputs("ra");
    repeat (2) begin
      step();
      chk("ra_hold_rspv", 32'(rspValid), 32'h0);
    end
    @(negedge clk) nReset = 1'b1;
    ready = 1'b1; reqValid = 2'b11;
    #1 chk("ra_post_grant", 32'(reqReady), 32'h1);
    step(); reqValid = 2'b00;
    chk("ra_post_rspv0", 32'(rspValid), 32'h0);
    step();
    step();
    chk("ra_post_rspv", 32'(rspValid), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
